// File: rtl/control_pkg.sv
// Shared opcodes, ALU constants, FSM encoding and instruction field layout
// for the control_unit fetch/execute sequencer.
package control_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JN   = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam int unsigned F_OPC_LSB = 12;
    localparam int unsigned F_D_LSB   = 10;
    localparam int unsigned F_A_LSB   = 8;
    localparam int unsigned F_B_LSB   = 6;
    localparam int unsigned F_ALU_LSB = 0;
    localparam int unsigned F_IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_Z      = 2'd1,
        COND_C      = 2'd2,
        COND_N      = 2'd3
    } cond_t;

    typedef struct packed {
        logic       load_enable;
        logic       mb_select;
        logic       md_select;
        logic       write_ram_enable;
        logic [1:0] a_select;
        logic [1:0] b_select;
        logic [1:0] destination_select;
        logic [2:0] operation_select;
        logic [7:0] constant_in;
    } ctrl_t;

    typedef struct packed {
        logic       is_branch;
        cond_t      cond;
        logic       is_halt;
        logic       is_illegal;
        logic       updates_flags;
        logic [7:0] target;
    } flow_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[F_OPC_LSB +: 4];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// data_unit control word and ALU flag bus between control_unit and data_unit.
interface control_unit_if;

    logic       load_enable;
    logic       mb_select;
    logic       md_select;
    logic       write_ram_enable;
    logic [1:0] a_select;
    logic [1:0] b_select;
    logic [1:0] destination_select;
    logic [2:0] operation_select;
    logic [7:0] constant_in;
    logic       zero_flag;
    logic       carrier_flag;
    logic       negative_flag;

    modport master (
        output load_enable, mb_select, md_select, write_ram_enable,
        output a_select, b_select, destination_select, operation_select, constant_in,
        input  zero_flag, carrier_flag, negative_flag
    );

    modport slave (
        input  load_enable, mb_select, md_select, write_ram_enable,
        input  a_select, b_select, destination_select, operation_select, constant_in,
        output zero_flag, carrier_flag, negative_flag
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of one 16-bit instruction into the data_unit control
// word and the sequencing attributes (branch, halt, illegal, flag update).
module instr_decoder
    import control_pkg::*;
(
    input  logic [15:0] instr,
    output ctrl_t       ctrl,
    output flow_t       flow
);

    logic [1:0] fld_d;
    logic [1:0] fld_a;
    logic [1:0] fld_b;
    logic [2:0] fld_alu;
    logic [7:0] fld_imm;

    assign fld_d   = instr[F_D_LSB +: 2];
    assign fld_a   = instr[F_A_LSB +: 2];
    assign fld_b   = instr[F_B_LSB +: 2];
    assign fld_alu = instr[F_ALU_LSB +: 3];
    assign fld_imm = instr[F_IMM_LSB +: 8];

    always_comb begin
        ctrl        = '0;
        flow        = '0;
        flow.target = fld_imm;
        case (opcode_of(instr))
            OP_NOP: ;
            OP_ALU: begin
                ctrl.operation_select   = fld_alu;
                ctrl.a_select           = fld_a;
                ctrl.b_select           = fld_b;
                ctrl.destination_select = fld_d;
                ctrl.load_enable        = 1'b1;
                flow.updates_flags      = 1'b1;
            end
            OP_LDI: begin
                ctrl.operation_select   = ALU_PASS_B;
                ctrl.mb_select          = 1'b1;
                ctrl.constant_in        = fld_imm;
                ctrl.destination_select = fld_d;
                ctrl.load_enable        = 1'b1;
                flow.updates_flags      = 1'b1;
            end
            OP_ADDI: begin
                ctrl.operation_select   = ALU_ADD;
                ctrl.a_select           = fld_a;
                ctrl.mb_select          = 1'b1;
                ctrl.constant_in        = fld_imm;
                ctrl.destination_select = fld_d;
                ctrl.load_enable        = 1'b1;
                flow.updates_flags      = 1'b1;
            end
            OP_LD: begin
                ctrl.md_select          = 1'b1;
                ctrl.a_select           = fld_a;
                ctrl.destination_select = fld_d;
                ctrl.load_enable        = 1'b1;
            end
            OP_ST: begin
                ctrl.write_ram_enable = 1'b1;
                ctrl.a_select         = fld_a;
                ctrl.b_select         = fld_b;
            end
            OP_JMP: begin
                flow.is_branch = 1'b1;
                flow.cond      = COND_ALWAYS;
            end
            OP_JZ: begin
                flow.is_branch = 1'b1;
                flow.cond      = COND_Z;
            end
            OP_JC: begin
                flow.is_branch = 1'b1;
                flow.cond      = COND_C;
            end
            OP_JN: begin
                flow.is_branch = 1'b1;
                flow.cond      = COND_N;
            end
            OP_HLT:  flow.is_halt    = 1'b1;
            default: flow.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Two-cycle FETCH/EXEC sequencer driving the data_unit control word from an
// external instruction ROM; control outputs are registered and live only in EXEC.
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         instruction_in,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    control_unit_if.master      du
);

    state_t              state;
    state_t              state_n;
    logic [PC_WIDTH-1:0] pc_n;
    logic [2:0]          flags_q;
    logic [2:0]          flags_n;
    logic                illegal_n;
    logic                taken;
    ctrl_t               dec_ctrl;
    ctrl_t               ctrl_q;
    ctrl_t               ctrl_n;
    flow_t               dec_flow;
    flow_t               flow_q;
    flow_t               flow_n;

    instr_decoder u_decoder (
        .instr (instruction_in),
        .ctrl  (dec_ctrl),
        .flow  (dec_flow)
    );

    // IR is captured in decoded form at the end of FETCH so the control
    // outputs come straight from flops during EXEC; reset value decodes as NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            flags_q <= '0;
            illegal <= 1'b0;
            ctrl_q  <= '0;
            flow_q  <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            flags_q <= flags_n;
            illegal <= illegal_n;
            ctrl_q  <= ctrl_n;
            flow_q  <= flow_n;
        end
    end

    always_comb begin
        case (flow_q.cond)
            COND_Z:  taken = flags_q[0];
            COND_C:  taken = flags_q[1];
            COND_N:  taken = flags_q[2];
            default: taken = 1'b1;
        endcase
        taken = taken & flow_q.is_branch;
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        flags_n   = flags_q;
        illegal_n = illegal;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n   = S_FETCH;
                    pc_n      = '0;
                    flags_n   = '0;
                    illegal_n = 1'b0;
                end
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                if (flow_q.updates_flags)
                    flags_n = {du.negative_flag, du.carrier_flag, du.zero_flag};
                if (flow_q.is_halt || flow_q.is_illegal) begin
                    state_n   = S_HALT;
                    illegal_n = illegal | flow_q.is_illegal;
                end else begin
                    state_n = S_FETCH;
                    pc_n    = taken ? PC_WIDTH'(flow_q.target) : pc + PC_WIDTH'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_n = '0;
        flow_n = flow_q;
        if (state == S_FETCH) begin
            ctrl_n = dec_ctrl;
            flow_n = dec_flow;
        end
    end

    assign busy   = (state == S_FETCH) || (state == S_EXEC);
    assign halted = (state == S_HALT);

    assign du.load_enable        = ctrl_q.load_enable;
    assign du.mb_select          = ctrl_q.mb_select;
    assign du.md_select          = ctrl_q.md_select;
    assign du.write_ram_enable   = ctrl_q.write_ram_enable;
    assign du.a_select           = ctrl_q.a_select;
    assign du.b_select           = ctrl_q.b_select;
    assign du.destination_select = ctrl_q.destination_select;
    assign du.operation_select   = ctrl_q.operation_select;
    assign du.constant_in        = ctrl_q.constant_in;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level reference model
// queues per-cycle expectations; a negedge monitor compares DUT outputs.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instruction_in;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] rom [0:255];

    control_unit_if du_if ();

    control_unit #(.PC_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .instruction_in (instruction_in),
        .pc             (pc),
        .busy           (busy),
        .halted         (halted),
        .illegal        (illegal),
        .du             (du_if)
    );

    assign instruction_in = rom[pc];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic       busy;
        logic       halted;
        logic       illegal;
        logic       le;
        logic       mb;
        logic       md;
        logic       we;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] d;
        logic [2:0] op;
        logic [7:0] k;
    } obs_t;

    obs_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic obs_t observe();
        obs_t o;
        o.pc      = pc;
        o.busy    = busy;
        o.halted  = halted;
        o.illegal = illegal;
        o.le      = du_if.load_enable;
        o.mb      = du_if.mb_select;
        o.md      = du_if.md_select;
        o.we      = du_if.write_ram_enable;
        o.a       = du_if.a_select;
        o.b       = du_if.b_select;
        o.d       = du_if.destination_select;
        o.op      = du_if.operation_select;
        o.k       = du_if.constant_in;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got pc=%h bsy=%b hlt=%b ill=%b le=%b mb=%b md=%b we=%b a=%0d b=%0d d=%0d op=%0d k=%h expected pc=%h bsy=%b hlt=%b ill=%b le=%b mb=%b md=%b we=%b a=%0d b=%0d d=%0d op=%0d k=%h",
                     name, $time, act.pc, act.busy, act.halted, act.illegal, act.le, act.mb, act.md, act.we,
                     act.a, act.b, act.d, act.op, act.k, exp.pc, exp.busy, exp.halted, exp.illegal, exp.le,
                     exp.mb, exp.md, exp.we, exp.a, exp.b, exp.d, exp.op, exp.k);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cycle", observe(), e);
        end
    end

    // Expected EXEC-cycle outputs straight from the opcode table.
    function automatic obs_t exec_obs(input logic [7:0] pcv, input logic [15:0] ins);
        obs_t o;
        o      = '0;
        o.pc   = pcv;
        o.busy = 1'b1;
        case (ins[15:12])
            4'h1: begin o.le = 1'b1; o.op = ins[2:0]; o.a = ins[9:8]; o.b = ins[7:6]; o.d = ins[11:10]; end
            4'h2: begin o.le = 1'b1; o.op = 3'b100; o.mb = 1'b1; o.k = ins[7:0]; o.d = ins[11:10]; end
            4'h3: begin o.le = 1'b1; o.op = 3'b000; o.mb = 1'b1; o.k = ins[7:0]; o.a = ins[9:8]; o.d = ins[11:10]; end
            4'h4: begin o.le = 1'b1; o.md = 1'b1; o.a = ins[9:8]; o.d = ins[11:10]; end
            4'h5: begin o.we = 1'b1; o.a = ins[9:8]; o.b = ins[7:6]; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic drive_flags(input logic [2:0] f);
        du_if.zero_flag     = f[0];
        du_if.carrier_flag  = f[1];
        du_if.negative_flag = f[2];
    endtask

    task automatic push_idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('0);
            @(posedge clk) #1;
        end
    endtask

    // Pulse start, then model up to max_instr instructions; returns whether it halted.
    task automatic run_program(input int max_instr, input bit fixed,
                               input logic [2:0] fflags, output bit stopped);
        logic [7:0]  m_pc;
        logic [7:0]  nxt;
        logic [2:0]  m_flags;
        logic [2:0]  fl;
        logic        m_ill;
        logic [15:0] ins;
        obs_t        o;
        start = 1'b1;
        @(posedge clk) #1;
        start   = 1'b0;
        m_pc    = 8'h00;
        m_flags = 3'b000;
        m_ill   = 1'b0;
        stopped = 1'b0;
        for (int i = 0; i < max_instr && !stopped; i++) begin
            ins    = rom[m_pc];
            o      = '0;
            o.pc   = m_pc;
            o.busy = 1'b1;
            exp_q.push_back(o);
            drive_flags(3'($urandom));
            @(posedge clk) #1;
            fl = fixed ? fflags : 3'($urandom);
            drive_flags(fl);
            exp_q.push_back(exec_obs(m_pc, ins));
            nxt = m_pc + 8'd1;
            case (ins[15:12])
                4'h6: nxt = ins[7:0];
                4'h7: if (m_flags[0]) nxt = ins[7:0];
                4'h8: if (m_flags[1]) nxt = ins[7:0];
                4'h9: if (m_flags[2]) nxt = ins[7:0];
                4'hF: stopped = 1'b1;
                4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin stopped = 1'b1; m_ill = 1'b1; end
                default: ;
            endcase
            if (ins[15:12] inside {4'h1, 4'h2, 4'h3})
                m_flags = fl;
            @(posedge clk) #1;
            if (stopped) begin
                o         = '0;
                o.pc      = m_pc;
                o.halted  = 1'b1;
                o.illegal = m_ill;
                exp_q.push_back(o);
                @(posedge clk) #1;
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1 check("reset_async", observe(), '0);
        @(posedge clk) #1;
        reset = 1'b1;
        push_idle_cycles(2);
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    initial begin
        bit         st;
        logic [3:0] opc;
        int         r;
        obs_t       o;
        reset = 1'b0;
        start = 1'b0;
        drive_flags(3'b000);
        fill_rom(16'hF000);
        #2 check("reset_state", observe(), '0);
        @(posedge clk) #1;
        reset = 1'b1;
        push_idle_cycles(2);

        // LDI r0,10; LDI r1,20; ALU r0=r0+r1; HLT
        rom[0] = 16'h200A;
        rom[1] = 16'h2514;
        rom[2] = 16'h1040;
        rom[3] = 16'hF000;
        run_program(10, 1'b0, 3'b000, st);
        if (!st) do_reset();

        // Conditional branches, taken and not taken, for Z, C and N.
        for (int c = 0; c < 3; c++) begin
            for (int t = 0; t < 2; t++) begin
                fill_rom(16'hF000);
                rom[0] = 16'h1000;
                rom[1] = {4'(4'h7 + c), 12'h020};
                run_program(10, 1'b1, (t == 1) ? 3'(1 << c) : ~3'(1 << c), st);
                if (!st) do_reset();
            end
        end

        // ST r2->[r0]; LD r3<-[r0]; JMP to HLT
        fill_rom(16'hF000);
        rom[0] = 16'h5080;
        rom[1] = 16'h4C00;
        rom[2] = 16'h6040;
        run_program(10, 1'b0, 3'b000, st);
        if (!st) do_reset();

        // All-NOP ROM: pc wraps 0xFF -> 0x00 with busy held high.
        fill_rom(16'h0000);
        run_program(258, 1'b0, 3'b000, st);
        if (!st) do_reset();

        // Illegal opcode, then restart clears the sticky flag.
        fill_rom(16'hF000);
        rom[0] = 16'hB123;
        run_program(4, 1'b0, 3'b000, st);
        rom[0] = 16'hF000;
        run_program(4, 1'b0, 3'b000, st);
        if (!st) do_reset();

        // Randomized programs.
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 99);
                if (r < 3)      opc = 4'($urandom_range(10, 14));
                else if (r < 7) opc = 4'hF;
                else            opc = 4'($urandom_range(0, 9));
                rom[i] = {opc, 12'($urandom)};
            end
            run_program(40, 1'b0, 3'b000, st);
            if (!st) do_reset();
        end

        // Reset dropped in the middle of an ST EXEC cycle.
        fill_rom(16'hF000);
        rom[0] = 16'h5080;
        start = 1'b1;
        @(posedge clk) #1;
        start  = 1'b0;
        o      = '0;
        o.busy = 1'b1;
        exp_q.push_back(o);
        @(posedge clk) #1;
        exp_q.push_back(exec_obs(8'h00, 16'h5080));
        @(negedge clk) #1;
        reset = 1'b0;
        #1 check("reset_mid_exec", observe(), '0);
        @(posedge clk) #1;
        reset = 1'b1;
        push_idle_cycles(3);

        @(posedge clk) #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
